bayes_seq_ctrl: RTL and testbench
=================================

BAYES_SEQ_CTRL -- requirements
Module: bayes_seq_ctrl

Interface
REQ-001 Parameter NUM_CLASS, 10, number of classes scored per classification.
REQ-002 Parameter NUM_ATTR, 784, number of attributes (pixels) per class.
REQ-003 Parameter PROB_W, 16, width of the signed log-probability word returned by the table.
REQ-004 Parameter ACC_W, 26, width of the signed class-score accumulator; SHALL be >= PROB_W + ceil(log2(NUM_ATTR)).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 start  input  1  request a classification; sampled only in IDLE.
REQ-009 abort  input  1  cancel the run in progress; no result is produced.
REQ-010 rd_en  output  1  table read strobe; address is valid when high.
REQ-011 c_idx  output  4  class index of the current read.
REQ-012 attri_idx  output  10  attribute index of the current read.
REQ-013 prob_data  input  PROB_W  signed log-probability; valid exactly 1 cycle after its rd_en.
REQ-014 busy  output  1  high from the cycle after start is accepted until done.
REQ-015 done  output  1  one-cycle pulse; result outputs valid in that cycle.
REQ-016 result_class  output  4  winning class index.
REQ-017 result_score  output  ACC_W  accumulated score of the winning class.

Function
REQ-018 FSM states are IDLE, RUN, DRAIN and DONE; state is IDLE after reset.
REQ-019 IDLE: start=1 -> RUN; c_idx=0 and attri_idx=0 on the next cycle; start while not IDLE is ignored.
REQ-020 RUN: rd_en=1 every cycle; attri_idx increments by 1 per cycle; at NUM_ATTR-1 it wraps to 0 and c_idx increments.
REQ-021 RUN: the read at (NUM_CLASS-1, NUM_ATTR-1) is the last one; next state is DRAIN.
REQ-022 DRAIN: rd_en=0 and the last prob_data is absorbed; next state is DONE.
REQ-023 DONE: done=1 and busy=0 for one cycle; next state is IDLE.
REQ-024 Latency: start sampled at edge k -> rd_en high for cycles k+1..k+NUM_CLASS*NUM_ATTR; done high in cycle k+NUM_CLASS*NUM_ATTR+2.
REQ-025 Accumulator: the block adds sign-extended prob_data in every cycle after an rd_en; addition is wrap-free and unsaturated.
REQ-026 When the data for a class's last attribute is absorbed, the block compares the completed sum with the best score and clears the accumulator for the next class.
REQ-027 Best score is initialised to the most negative ACC_W value at run start, so class 0 always wins its comparison.
REQ-028 A class replaces the best only if its sum is strictly greater; on a tie the lower index is kept.
REQ-029 result_class and result_score update only in the DONE cycle and hold until the next DONE or reset.
REQ-030 abort=1 in RUN or DRAIN -> IDLE next cycle; rd_en=0, busy=0 and no done pulse; results are unchanged; abort in IDLE or DONE is ignored.
REQ-031 abort and start both high in IDLE: start wins.
REQ-032 c_idx and attri_idx hold their last values when rd_en=0.

Reset
REQ-033 While rst=1: state IDLE, rd_en=0, busy=0, done=0, c_idx=0, attri_idx=0, accumulator=0, result_class=0, result_score=0, independent of clk.
REQ-034 rst asserted mid-run aborts immediately with no done pulse; the first start after reset release begins a fresh run at (0,0).

Verification
REQ-035 NUM_CLASS=3, NUM_ATTR=4, start at edge 0 -> rd_en cycles 1..12 with (c,a) = (0,0),(0,1)..(2,3); done in cycle 14.
REQ-036 Same parameters; table returns c*10+a -> class sums 6, 46, 86; result_class=2, result_score=86.
REQ-037 Table returns -5 for class 0, +3 for class 1 and +3 for class 2 -> sums -20, 12, 12; result_class=1 (tie keeps lower), result_score=12.
REQ-038 abort at cycle 6 -> rd_en=0 from cycle 7, no done, previous results held; a new start runs the full sequence correctly.
REQ-039 start pulsed during RUN -> ignored; exactly one done and 12 reads; async rst mid-run -> all outputs zero without a clock edge.
REQ-040 Default parameters with every prob_data=-1 -> done at k+7842; result_class=0, result_score=-784.

Source files
------------

// File: rtl/bayes_seq_ctrl.sv
// bayes_seq_ctrl: sequences log-probability table reads over all
// (class, attribute) pairs. It accumulates one score per class and
// reports the highest-scoring class, keeping the lower index on a tie.
module bayes_seq_ctrl #(
    parameter int NUM_CLASS = 10,
    parameter int NUM_ATTR  = 784,
    parameter int PROB_W    = 16,
    parameter int ACC_W     = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              rd_en,
    output logic [3:0]        c_idx,
    output logic [9:0]        attri_idx,
    input  logic [PROB_W-1:0] prob_data,
    output logic              busy,
    output logic              done,
    output logic [3:0]        result_class,
    output logic [ACC_W-1:0]  result_score
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [3:0] LAST_C = 4'(NUM_CLASS - 1);
    localparam logic [9:0] LAST_A = 10'(NUM_ATTR - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  best;
    logic [3:0]               best_cls;
    // Tags travelling one cycle behind rd_en, aligned with prob_data.
    logic                     data_vld;
    logic                     data_last;
    logic [3:0]               data_cls;

    logic signed [ACC_W-1:0]  prob_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  nxt_best;
    logic [3:0]               nxt_cls;

    // Running sum and best-so-far, including the class completing this cycle.
    always_comb begin
        prob_ext = ACC_W'($signed(prob_data));
        sum      = acc + prob_ext;
        nxt_best = best;
        nxt_cls  = best_cls;
        if (data_vld && data_last && (sum > best)) begin
            nxt_best = sum;
            nxt_cls  = data_cls;
        end
    end

    // Sequencer FSM, score accumulation and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rd_en        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            c_idx        <= '0;
            attri_idx    <= '0;
            acc          <= '0;
            best         <= ACC_MIN;
            best_cls     <= '0;
            data_vld     <= 1'b0;
            data_last    <= 1'b0;
            data_cls     <= '0;
            result_class <= '0;
            result_score <= '0;
        end else begin
            done      <= 1'b0;
            data_vld  <= rd_en;
            data_last <= (attri_idx == LAST_A);
            data_cls  <= c_idx;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        rd_en     <= 1'b1;
                        busy      <= 1'b1;
                        c_idx     <= '0;
                        attri_idx <= '0;
                        acc       <= '0;
                        best      <= ACC_MIN;
                        best_cls  <= '0;
                    end
                end
                RUN, DRAIN: begin
                    if (abort) begin
                        state    <= IDLE;
                        rd_en    <= 1'b0;
                        busy     <= 1'b0;
                        data_vld <= 1'b0;
                    end else begin
                        if (data_vld) begin
                            acc      <= data_last ? '0 : sum;
                            best     <= nxt_best;
                            best_cls <= nxt_cls;
                        end
                        if (state == RUN) begin
                            if (c_idx == LAST_C && attri_idx == LAST_A) begin
                                state <= DRAIN;
                                rd_en <= 1'b0;
                            end else if (attri_idx == LAST_A) begin
                                attri_idx <= '0;
                                c_idx     <= c_idx + 4'd1;
                            end else begin
                                attri_idx <= attri_idx + 10'd1;
                            end
                        end else begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            result_class <= nxt_cls;
                            result_score <= nxt_best;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bayes_seq_ctrl.sv
// Testbench for bayes_seq_ctrl: small-parameter instance with random and
// directed tables against an argmax reference model, plus a default-size
// instance for the full-length latency case.
module tb_bayes_seq_ctrl;

    localparam int NC    = 3;
    localparam int NA    = 4;
    localparam int PW    = 16;
    localparam int AW    = 20;
    localparam int NREAD = NC * NA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, abort;
    logic          rd_en, busy, done;
    logic [3:0]    c_idx, result_class;
    logic [9:0]    attri_idx;
    logic [PW-1:0] prob_data;
    logic [AW-1:0] result_score;

    logic          start_b, rd_en_b, busy_b, done_b;
    logic [3:0]    c_idx_b, result_class_b;
    logic [9:0]    attri_idx_b;
    logic [15:0]   prob_data_b;
    logic [25:0]   result_score_b;

    assign prob_data_b = 16'hFFFF;

    bayes_seq_ctrl #(.NUM_CLASS(NC), .NUM_ATTR(NA), .PROB_W(PW), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rd_en(rd_en), .c_idx(c_idx), .attri_idx(attri_idx), .prob_data(prob_data),
        .busy(busy), .done(done), .result_class(result_class), .result_score(result_score)
    );

    bayes_seq_ctrl dut_big (
        .clk(clk), .rst(rst), .start(start_b), .abort(1'b0),
        .rd_en(rd_en_b), .c_idx(c_idx_b), .attri_idx(attri_idx_b), .prob_data(prob_data_b),
        .busy(busy_b), .done(done_b), .result_class(result_class_b), .result_score(result_score_b)
    );

    int     checks   = 0;
    int     failures = 0;
    int     tbl [NC][NA];
    int     exp_cls;
    longint exp_score;

    logic       smp_rd;
    logic [3:0] smp_c;
    logic [9:0] smp_a;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Table model: data for a read appears one cycle after its rd_en; otherwise a poison word.
    initial begin
        prob_data = '0;
        forever begin
            @(negedge clk);
            smp_rd = rd_en;
            smp_c  = c_idx;
            smp_a  = attri_idx;
            @(posedge clk);
            #1;
            if (smp_rd && int'(smp_c) < NC && int'(smp_a) < NA)
                prob_data = PW'(tbl[int'(smp_c)][int'(smp_a)]);
            else
                prob_data = 16'h7ABC;
        end
    end

    // Reference: per-class sums, strict-greater argmax starting from class 0.
    task automatic model();
        longint s;
        longint bst;
        bst     = -(longint'(1) << (AW - 1));
        exp_cls = 0;
        for (int c = 0; c < NC; c++) begin
            s = 0;
            for (int a = 0; a < NA; a++) s += tbl[c][a];
            if (s > bst) begin
                bst     = s;
                exp_cls = c;
            end
        end
        exp_score = bst;
    endtask

    task automatic fill(input int mode);
        for (int c = 0; c < NC; c++)
            for (int a = 0; a < NA; a++)
                case (mode)
                    0: tbl[c][a] = c * 10 + a;
                    1: tbl[c][a] = (c == 0) ? -5 : 3;
                    2: tbl[c][a] = -32768;
                    default: tbl[c][a] = int'($urandom_range(0, 8000)) - 4000;
                endcase
        if (mode == 4)
            for (int a = 0; a < NA; a++) tbl[2][a] = tbl[1][a];
    endtask

    task automatic run_full(input string tag, input bit mid_start, input bit with_abort);
        int reads;
        int done_at;
        int done_cnt;
        model();
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        reads = 0; done_at = -1; done_cnt = 0;
        for (int n = 1; n <= NREAD + 6; n++) begin
            @(negedge clk);
            check({tag, " rd_en"}, longint'(rd_en), longint'(n <= NREAD));
            check({tag, " busy"}, longint'(busy), longint'(n <= NREAD + 1));
            if (rd_en) begin
                check({tag, " c_idx"}, longint'(c_idx), longint'(reads / NA));
                check({tag, " attri_idx"}, longint'(attri_idx), longint'(reads % NA));
                reads++;
            end
            if (done) begin
                done_cnt++;
                done_at = n;
                check({tag, " result_class"}, longint'(result_class), longint'(exp_cls));
                check({tag, " result_score"}, longint'($signed(result_score)), exp_score);
            end
            start = (mid_start && n == 5) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check({tag, " reads"}, longint'(reads), longint'(NREAD));
        check({tag, " done count"}, longint'(done_cnt), 1);
        check({tag, " done cycle"}, longint'(done_at), longint'(NREAD + 2));
        check({tag, " class held"}, longint'(result_class), longint'(exp_cls));
        check({tag, " score held"}, longint'($signed(result_score)), exp_score);
    endtask

    task automatic run_abort(input string tag);
        int     pc;
        longint ps;
        pc = exp_cls;
        ps = exp_score;
        fill(3);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= NREAD + 6; n++) begin
            @(negedge clk);
            check({tag, " rd_en"}, longint'(rd_en), longint'(n <= 6));
            check({tag, " busy"}, longint'(busy), longint'(n <= 6));
            check({tag, " no done"}, longint'(done), 0);
            abort = (n == 6) ? 1'b1 : 1'b0;
        end
        abort = 1'b0;
        check({tag, " class held"}, longint'(result_class), longint'(pc));
        check({tag, " score held"}, longint'($signed(result_score)), ps);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rd_en"}, longint'(rd_en), 0);
        check({tag, " busy"}, longint'(busy), 0);
        check({tag, " done"}, longint'(done), 0);
        check({tag, " c_idx"}, longint'(c_idx), 0);
        check({tag, " attri_idx"}, longint'(attri_idx), 0);
        check({tag, " result_class"}, longint'(result_class), 0);
        check({tag, " result_score"}, longint'(result_score), 0);
    endtask

    initial begin
        int done_at;
        rst = 1'b1; start = 1'b0; abort = 1'b0; start_b = 1'b0;
        #1;
        check_zero("reset");
        check("reset big score", longint'(result_score_b), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        fill(0); run_full("ramp", 1'b0, 1'b0);
        fill(1); run_full("tie", 1'b0, 1'b0);
        fill(2); run_full("minval", 1'b0, 1'b0);
        fill(4); run_full("rand_tie", 1'b0, 1'b0);
        fill(3); run_full("rand_midstart", 1'b1, 1'b0);
        fill(3); run_full("rand_startabort", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            fill(3); run_full("rand", 1'b0, 1'b0);
        end

        run_abort("abort");
        fill(3); run_full("after_abort", 1'b0, 1'b0);

        // Asynchronous reset mid-run, checked before the next clock edge.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-rst rd_en", longint'(rd_en), 1);
        rst = 1'b1;
        #1;
        check_zero("async rst");
        repeat (2) @(negedge clk);
        check_zero("rst held");
        rst = 1'b0;
        fill(3); run_full("after_rst", 1'b0, 1'b0);

        // Default-size instance, every table word -1.
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        done_at = -1;
        for (int n = 1; n <= 8000; n++) begin
            @(negedge clk);
            if (done_b) begin
                done_at = n;
                break;
            end
        end
        check("big done cycle", longint'(done_at), 7842);
        check("big result_class", longint'(result_class_b), 0);
        check("big result_score", longint'($signed(result_score_b)), -784);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
